// File: rtl/switch_alloc_3port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_alloc_3port_pkg
//  Description : Shared constants and helpers for the 3-port switch allocator:
//                one-hot route codes, port indices, credit counter width and
//                the round-robin pick function.
//  Revision    : 1.0  initial release
// ============================================================================
package switch_alloc_3port_pkg;

    // Route codes carried on req_port_i (one-hot output port)
    localparam logic [2:0] c_EMPTY          = 3'b000;
    localparam logic [2:0] c_OUT_X1_PORT    = 3'b001;
    localparam logic [2:0] c_OUT_Y1_PORT    = 3'b010;
    localparam logic [2:0] c_OUT_LOCAL_PORT = 3'b100;

    // Port index map, shared by inputs and outputs
    localparam logic [1:0] c_IDX_X1    = 2'd0;
    localparam logic [1:0] c_IDX_Y1    = 2'd1;
    localparam logic [1:0] c_IDX_LOCAL = 2'd2;

    // Credit counter width; holds depths 1..7
    localparam int c_CRDT_W = 3;

    // Index -> one-hot select over the three ports
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            c_IDX_X1:    v = 3'b001;
            c_IDX_Y1:    v = 3'b010;
            c_IDX_LOCAL: v = 3'b100;
            default:     v = 3'b000;
        endcase
        return v;
    endfunction

    // First requester scanning upward from ptr+1 (mod 3); caller checks |req
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        case (ptr)
            2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
            2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
            default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
        endcase
        if (req[a])      return a;
        else if (req[b]) return b;
        else             return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_alloc_3port_sa_out_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sa_out_arb
//  Description : Per-output arbiter: IDLE/LOCKED wormhole lock, round-robin
//                pointer and downstream credit counter for one output port.
//  Revision    : 1.0  initial release
// ============================================================================
module sa_out_arb
    import switch_alloc_3port_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,         // inputs requesting this output (valid-qualified)
    input  logic [2:0] i_flit_valid,
    input  logic [2:0] i_flit_tail,
    input  logic       i_credit,
    output logic       o_valid,
    output logic [2:0] o_ready,       // one-hot: owner input consumed a flit
    output logic [2:0] o_sel
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;
    localparam logic [c_CRDT_W-1:0] c_CRDT_FULL = c_CRDT_W'(CREDIT_DEPTH);

    logic [0:0]          r_state;
    logic [1:0]          r_owner;
    logic [1:0]          r_rr_ptr;
    logic [c_CRDT_W-1:0] r_credit;
    logic [2:0]          r_sel;

    logic       w_xfer;
    logic [1:0] w_pick;

    assign w_xfer  = (r_state == c_ST_LOCKED) && i_flit_valid[r_owner] && (r_credit != '0);
    assign w_pick  = rr_pick(i_req, r_rr_ptr);
    assign o_valid = w_xfer;
    assign o_ready = w_xfer ? onehot3(r_owner) : 3'b000;
    assign o_sel   = r_sel;

    // Wormhole lock: grant in IDLE, hold through bubbles, release after the tail moves
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_owner  <= 2'd0;
            r_rr_ptr <= 2'd2;
            r_sel    <= 3'b000;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|i_req) begin
                        r_state <= c_ST_LOCKED;
                        r_owner <= w_pick;
                        r_sel   <= onehot3(w_pick);
                    end
                end
                c_ST_LOCKED: begin
                    if (w_xfer && i_flit_tail[r_owner]) begin
                        r_state  <= c_ST_IDLE;
                        r_rr_ptr <= r_owner;
                        r_sel    <= 3'b000;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_sel   <= 3'b000;
                end
            endcase
        end
    end

    // Credit tracking; a return while already full is dropped so the count never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= c_CRDT_FULL;
        end else if (w_xfer && !i_credit) begin
            r_credit <= r_credit - 1'b1;
        end else if (i_credit && !w_xfer && (r_credit != c_CRDT_FULL)) begin
            r_credit <= r_credit + 1'b1;
        end
    end

    // Downstream must never return a credit when no slot is outstanding
    a_no_credit_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_credit && !w_xfer && (r_credit == c_CRDT_FULL)));

endmodule
`default_nettype wire

// File: rtl/switch_alloc_3port.sv
`default_nettype none
// ============================================================================
//  Module      : switch_alloc_3port
//  Description : Output-side switch allocator for the 3-port mesh router.
//                Decodes per-input one-hot route codes into per-output
//                request vectors, runs one arbiter per output and merges the
//                per-output ready back onto the inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_alloc_3port
    import switch_alloc_3port_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] req_port_i,
    input  logic [2:0] flit_valid_i,
    input  logic [2:0] flit_tail_i,
    input  logic [2:0] credit_i,
    output logic [2:0] in_ready_o,
    output logic [2:0] out_valid_o,
    output logic [8:0] out_sel_o
);

    logic [2:0] w_out_req [3];
    logic [2:0] w_out_rdy [3];

    for (genvar o = 0; o < 3; o++) begin : g_out
        // Input i requests output o when its head flit is present and its code selects o
        for (genvar i = 0; i < 3; i++) begin : g_in
            assign w_out_req[o][i] = flit_valid_i[i] & req_port_i[3*i+o];
        end

        sa_out_arb #(
            .CREDIT_DEPTH (CREDIT_DEPTH)
        ) u_arb (
            .clk          (clk),
            .rst          (rst),
            .i_req        (w_out_req[o]),
            .i_flit_valid (flit_valid_i),
            .i_flit_tail  (flit_tail_i),
            .i_credit     (credit_i[o]),
            .o_valid      (out_valid_o[o]),
            .o_ready      (w_out_rdy[o]),
            .o_sel        (out_sel_o[3*o +: 3])
        );
    end

    // An input targets one output at a time, so a plain OR merges the grants
    assign in_ready_o = w_out_rdy[0] | w_out_rdy[1] | w_out_rdy[2];

endmodule
`default_nettype wire
